panda_lsu_pipe: RTL and testbench
=================================

PANDA_LSU_PIPE -- requirements
Module: panda_lsu_pipe

Interface
REQ-001 SHALL provide parameter BUS_WIDTH, default 32, memory data bus width in bits; legal values 32 or 64.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 255, maximum cycles in a wait state before a bus error is declared; 0 disables the timeout.
REQ-003 SHALL provide, in this order: clk_i, input, 1, the single clock; rst_i, input, 1, synchronous active-high reset.
REQ-004 SHALL provide core-side ports: req_i in 1 (request valid); store_i in 1; load_unsigned_i in 1; width_i in panda_pkg::lsu_width_e; addr_i in 32; store_data_i in 32; ready_o out 1 (request accepted this cycle).
REQ-005 SHALL provide core-side results: done_o out 1 (one-cycle completion pulse); load_data_o out 32; misaligned_o out 1; bus_err_o out 1.
REQ-006 SHALL provide memory-side ports: data_req_o out 1; data_gnt_i in 1; data_addr_o out 32; data_we_o out 1; data_be_o out BUS_WIDTH/8; data_wdata_o out BUS_WIDTH; data_rvalid_i in 1; data_err_i in 1; data_rdata_i in BUS_WIDTH.

Function
REQ-007 SHALL implement FSM states IDLE, WAIT_GNT, WAIT_RVALID; at most one outstanding transaction.
REQ-008 ready_o SHALL be 1 only in IDLE; a request is accepted when req_i && ready_o.
REQ-009 On acceptance, SHALL register addr, width, store flag, unsigned flag and lane-replicated write data; all memory-side outputs SHALL be driven from these registers.
REQ-010 Misalignment: HALF with addr[0]=1, or WORD with addr[1:0]!=0. On acceptance, SHALL pulse done_o and misaligned_o for one cycle, issue no bus request, and remain in IDLE.
REQ-011 Aligned acceptance SHALL move to WAIT_GNT with data_req_o=1 from the next cycle.
REQ-012 data_req_o and all data_* outputs SHALL stay stable in WAIT_GNT until data_gnt_i=1; on grant, data_req_o SHALL drop the next cycle and the FSM SHALL move to WAIT_RVALID.
REQ-013 data_addr_o SHALL equal the captured address with its low log2(BUS_WIDTH/8) bits cleared.
REQ-014 data_be_o SHALL be: BYTE 1 bit at lane offset; HALF 2 bits at offset; WORD 4 bits at offset (offset 0 or 4 when BUS_WIDTH=64); offset = addr[log2(BUS_WIDTH/8)-1:0].
REQ-015 data_wdata_o SHALL replicate the byte/half/word across the whole bus; data_we_o SHALL equal the captured store flag.
REQ-016 In WAIT_RVALID, on data_rvalid_i=1, SHALL pulse done_o next cycle and return to IDLE; bus_err_o SHALL pulse with done_o iff data_err_i=1 in that cycle.
REQ-017 Loads: SHALL extract the lane at offset from data_rdata_i, zero- or sign-extend to 32 bits per the unsigned flag, and hold load_data_o from the done_o cycle until the next load completes; load_data_o SHALL be 0 on errored loads and unchanged by stores.
REQ-018 A cycle counter SHALL clear on every state entry and increment in WAIT_GNT/WAIT_RVALID; on reaching TIMEOUT_CYCLES (non-zero) SHALL pulse done_o and bus_err_o and return to IDLE, dropping data_req_o.
REQ-019 A data_rvalid_i arriving in IDLE or WAIT_GNT SHALL be ignored.
REQ-020 A grant and rvalid in the same WAIT_GNT cycle SHALL be treated as grant only.
REQ-021 Back-to-back: a new request SHALL be acceptable in the cycle following done_o.

Reset
REQ-022 While rst_i=1 at a clock edge, SHALL enter IDLE and drive data_req_o=0, done_o=0, misaligned_o=0, bus_err_o=0, load_data_o=0, data_we_o=0, data_be_o=0, data_addr_o=0, data_wdata_o=0, and clear the counter.
REQ-023 Reset in WAIT_GNT or WAIT_RVALID SHALL abandon the transaction without a done_o pulse; ready_o=1 the cycle after rst_i deasserts.

Verification
REQ-024 BUS_WIDTH=32, LB addr 0x103, gnt after 2 cycles, rdata 0x80AABBCC -> data_be_o=4'b1000, load_data_o=0xFFFFFF80, single done_o.
REQ-025 BUS_WIDTH=64, SH addr 0x206, data 0x1234ABCD, immediate gnt/rvalid -> data_addr_o=0x200, data_be_o=8'hC0, data_wdata_o=0xABCDABCDABCDABCD, data_we_o=1.
REQ-026 LW addr 0x102 -> done_o and misaligned_o pulse after 1 cycle, data_req_o never asserts.
REQ-027 TIMEOUT_CYCLES=4, gnt withheld -> done_o and bus_err_o pulse after 4 wait cycles, data_req_o then 0, ready_o 1.
REQ-028 rst_i asserted in WAIT_RVALID, then late rvalid -> no done_o, load_data_o=0, rvalid ignored.

Source files
------------

// File: rtl/panda_lsu_pipe.sv
// panda_lsu_pipe: single-outstanding load/store unit between the core and a
// req/gnt/rvalid data bus. Requests are captured once on acceptance and every
// memory-side output is driven from those captured registers.

package panda_pkg;
  // Access size requested by the core.
  typedef enum logic [1:0] {
    LsuByte = 2'b00,
    LsuHalf = 2'b01,
    LsuWord = 2'b10
  } lsu_width_e;
endpackage

module panda_lsu_pipe #(
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // Core request side
  input  logic                     req_i,
  input  logic                     store_i,
  input  logic                     load_unsigned_i,
  input  panda_pkg::lsu_width_e    width_i,
  input  logic [31:0]              addr_i,
  input  logic [31:0]              store_data_i,
  output logic                     ready_o,
  // Core result side
  output logic                     done_o,
  output logic [31:0]              load_data_o,
  output logic                     misaligned_o,
  output logic                     bus_err_o,
  // Memory side
  output logic                     data_req_o,
  input  logic                     data_gnt_i,
  output logic [31:0]              data_addr_o,
  output logic                     data_we_o,
  output logic [BUS_WIDTH/8-1:0]   data_be_o,
  output logic [BUS_WIDTH-1:0]     data_wdata_o,
  input  logic                     data_rvalid_i,
  input  logic                     data_err_i,
  input  logic [BUS_WIDTH-1:0]     data_rdata_i
);

  localparam int unsigned NumBytes = BUS_WIDTH / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned CntW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);
  localparam bit TimeoutOn = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] WAIT_GNT    = 2'd1;
  localparam logic [1:0] WAIT_RVALID = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                  data_req_q, data_req_d;
  logic                  done_q, done_d;
  logic                  mis_q, mis_d;
  logic                  err_q, err_d;
  logic [31:0]           ldata_q, ldata_d;

  // Captured transaction
  logic [31:0]           addr_q;
  logic [OffW-1:0]       off_q;
  panda_pkg::lsu_width_e width_q;
  logic                  store_q;
  logic                  uns_q;
  logic [NumBytes-1:0]   be_q;
  logic [BUS_WIDTH-1:0]  wdata_q;

  // Values derived from the incoming request
  logic                  accept;
  logic                  misaligned_in;
  logic [OffW-1:0]       off_in;
  logic [NumBytes-1:0]   be_base;
  logic [NumBytes-1:0]   be_in;
  logic [BUS_WIDTH-1:0]  wdata_in;
  logic [31:0]           addr_in;

  // Values derived from the returning read data
  logic [31:0]           rd_lane;
  logic [31:0]           load_ext;
  logic                  timeout;

  assign ready_o = (state_q == IDLE);
  assign accept  = req_i && ready_o;
  assign off_in  = addr_i[OffW-1:0];
  assign addr_in = {addr_i[31:OffW], {OffW{1'b0}}};

  // Decode size of the incoming request: alignment, byte enables, replicated data.
  always_comb begin
    misaligned_in = 1'b0;
    be_base       = '0;
    wdata_in      = '0;
    case (width_i)
      panda_pkg::LsuByte: begin
        be_base  = NumBytes'(1);
        wdata_in = {NumBytes{store_data_i[7:0]}};
      end
      panda_pkg::LsuHalf: begin
        misaligned_in = addr_i[0];
        be_base       = NumBytes'(3);
        wdata_in      = {(NumBytes / 2){store_data_i[15:0]}};
      end
      default: begin
        misaligned_in = (addr_i[1:0] != 2'b00);
        be_base       = NumBytes'(15);
        wdata_in      = {(NumBytes / 4){store_data_i}};
      end
    endcase
    be_in = be_base << off_in;
  end

  // Select the addressed lane of the read data and extend it to 32 bits.
  always_comb begin
    rd_lane = 32'(data_rdata_i >> {off_q, 3'b000});
    case (width_q)
      panda_pkg::LsuByte:
        load_ext = uns_q ? {24'h0, rd_lane[7:0]} : {{24{rd_lane[7]}}, rd_lane[7:0]};
      panda_pkg::LsuHalf:
        load_ext = uns_q ? {16'h0, rd_lane[15:0]} : {{16{rd_lane[15]}}, rd_lane[15:0]};
      default:
        load_ext = rd_lane;
    endcase
  end

  assign cnt_inc = cnt_q + 1'b1;
  assign timeout = TimeoutOn && (cnt_inc == TimeoutVal);

  // FSM next state, wait counter and one-cycle result pulses.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_req_d = data_req_q;
    done_d     = 1'b0;
    mis_d      = 1'b0;
    err_d      = 1'b0;
    ldata_d    = ldata_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (misaligned_in) begin
            // Rejected without touching the bus.
            done_d = 1'b1;
            mis_d  = 1'b1;
          end else begin
            state_d    = WAIT_GNT;
            data_req_d = 1'b1;
          end
        end
      end
      WAIT_GNT: begin
        cnt_d = cnt_inc;
        // Grant wins over rvalid and over an expiring timeout.
        if (data_gnt_i) begin
          state_d    = WAIT_RVALID;
          data_req_d = 1'b0;
          cnt_d      = '0;
        end else if (timeout) begin
          state_d    = IDLE;
          data_req_d = 1'b0;
          cnt_d      = '0;
          done_d     = 1'b1;
          err_d      = 1'b1;
          if (!store_q) ldata_d = '0;
        end
      end
      WAIT_RVALID: begin
        cnt_d = cnt_inc;
        if (data_rvalid_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          err_d   = data_err_i;
          if (!store_q) ldata_d = data_err_i ? 32'h0 : load_ext;
        end else if (timeout) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          if (!store_q) ldata_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        cnt_d      = '0;
        data_req_d = 1'b0;
      end
    endcase
  end

  // State and result registers; reset abandons any transaction silently.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_req_q <= 1'b0;
      done_q     <= 1'b0;
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
      ldata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_req_q <= data_req_d;
      done_q     <= done_d;
      mis_q      <= mis_d;
      err_q      <= err_d;
      ldata_q    <= ldata_d;
    end
  end

  // Request capture; these registers alone drive the memory-side outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      off_q   <= '0;
      width_q <= panda_pkg::LsuByte;
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= addr_in;
      off_q   <= off_in;
      width_q <= width_i;
      store_q <= store_i;
      uns_q   <= load_unsigned_i;
      be_q    <= be_in;
      wdata_q <= wdata_in;
    end
  end

  assign done_o       = done_q;
  assign misaligned_o = mis_q;
  assign bus_err_o    = err_q;
  assign load_data_o  = ldata_q;
  assign data_req_o   = data_req_q;
  assign data_addr_o  = addr_q;
  assign data_we_o    = store_q;
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_panda_lsu_pipe.sv
// Bench for panda_lsu_pipe: a 32-bit instance (timeout 4) and a 64-bit
// instance (timeout 6) share core/bus stimulus, selected by `sel`. Results are
// predicted by a transaction-level model of the access rules.
module tb_panda_lsu_pipe;
  import panda_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req = 1'b0, store = 1'b0, uns = 1'b0;
  lsu_width_e  width = LsuByte;
  logic [31:0] addr = '0, sdata = '0;
  logic        gnt = 1'b0, rvalid = 1'b0, err = 1'b0;
  logic [63:0] rdata = '0;

  logic        ready32, done32, mis32, berr32, dreq32, we32;
  logic [31:0] ld32, daddr32, wd32;
  logic [3:0]  be32;
  logic        ready64, done64, mis64, berr64, dreq64, we64;
  logic [31:0] ld64, daddr64;
  logic [63:0] wd64;
  logic [7:0]  be64;

  panda_lsu_pipe #(.BUS_WIDTH(32), .TIMEOUT_CYCLES(4)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .req_i(req & ~sel), .store_i(store), .load_unsigned_i(uns),
    .width_i(width), .addr_i(addr), .store_data_i(sdata), .ready_o(ready32),
    .done_o(done32), .load_data_o(ld32), .misaligned_o(mis32), .bus_err_o(berr32),
    .data_req_o(dreq32), .data_gnt_i(gnt & ~sel), .data_addr_o(daddr32), .data_we_o(we32),
    .data_be_o(be32), .data_wdata_o(wd32), .data_rvalid_i(rvalid & ~sel), .data_err_i(err),
    .data_rdata_i(rdata[31:0])
  );

  panda_lsu_pipe #(.BUS_WIDTH(64), .TIMEOUT_CYCLES(6)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .req_i(req & sel), .store_i(store), .load_unsigned_i(uns),
    .width_i(width), .addr_i(addr), .store_data_i(sdata), .ready_o(ready64),
    .done_o(done64), .load_data_o(ld64), .misaligned_o(mis64), .bus_err_o(berr64),
    .data_req_o(dreq64), .data_gnt_i(gnt & sel), .data_addr_o(daddr64), .data_we_o(we64),
    .data_be_o(be64), .data_wdata_o(wd64), .data_rvalid_i(rvalid & sel), .data_err_i(err),
    .data_rdata_i(rdata)
  );

  // Observed view of whichever instance is selected
  logic        o_ready, o_done, o_mis, o_berr, o_dreq, o_we;
  logic [31:0] o_ld, o_addr;
  logic [7:0]  o_be;
  logic [63:0] o_wd;
  assign o_ready = sel ? ready64 : ready32;
  assign o_done  = sel ? done64  : done32;
  assign o_mis   = sel ? mis64   : mis32;
  assign o_berr  = sel ? berr64  : berr32;
  assign o_dreq  = sel ? dreq64  : dreq32;
  assign o_we    = sel ? we64    : we32;
  assign o_ld    = sel ? ld64    : ld32;
  assign o_addr  = sel ? daddr64 : daddr32;
  assign o_be    = sel ? be64    : {4'h0, be32};
  assign o_wd    = sel ? wd64    : {32'h0, wd32};

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_ld [2];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s (bus%0d): got 0x%0h expected 0x%0h", tag, sel ? 64 : 32, obs, exp);
  endtask

  function automatic int size_of(input lsu_width_e w);
    return (w == LsuByte) ? 1 : (w == LsuHalf) ? 2 : 4;
  endfunction

  function automatic logic [63:0] model_be(input lsu_width_e w, input logic [31:0] a,
                                           input int nb);
    logic [63:0] r = '0;
    int off = int'(a % nb);
    for (int i = 0; i < size_of(w); i++) r[off + i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] model_wdata(input lsu_width_e w, input logic [31:0] d,
                                              input int nb);
    logic [63:0] r = '0;
    int sz = size_of(w);
    for (int i = 0; i < nb; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input lsu_width_e w, input bit u,
                                             input logic [31:0] a, input logic [63:0] rd,
                                             input int nb);
    int off = int'(a % nb);
    logic [63:0] v = rd >> (8 * off);
    if (size_of(w) == 1) begin
      v = v & 64'hFF;
      if (!u && v[7]) v = v - 64'h100;
    end else if (size_of(w) == 2) begin
      v = v & 64'hFFFF;
      if (!u && v[15]) v = v - 64'h1_0000;
    end
    return v[31:0];
  endfunction

  // One full transaction starting at a negedge in IDLE; ends one cycle after done.
  task automatic do_txn(input bit st, input bit u, input lsu_width_e w, input logic [31:0] a,
                        input logic [31:0] sd, input int gd, input int rd, input bit e,
                        input logic [63:0] rdat);
    int nb  = sel ? 8 : 4;
    int tmo = sel ? 6 : 4;
    bit mis = (int'(a % size_of(w)) != 0);
    logic [31:0] ea = a & ~32'(nb - 1);
    logic [63:0] ebe = model_be(w, a, nb);
    logic [63:0] ewd = model_wdata(w, sd, nb);
    bit granted = 1'b0, timed = 1'b0, got = 1'b0;
    int k = 0;
    check_eq("ready_before_req", o_ready, 1);
    req = 1'b1; store = st; uns = u; width = w; addr = a; sdata = sd;
    gnt = 1'b0; rvalid = 1'b0; err = 1'b0;
    @(negedge clk);
    // Scramble core inputs: outputs must come from captured state only.
    req = 1'b0; store = $urandom_range(0, 1); uns = $urandom_range(0, 1);
    width = lsu_width_e'($urandom_range(0, 2)); addr = $urandom; sdata = $urandom;
    if (mis) begin
      check_eq("mis_done", o_done, 1);
      check_eq("mis_flag", o_mis, 1);
      check_eq("mis_berr", o_berr, 0);
      check_eq("mis_no_req", o_dreq, 0);
      check_eq("mis_ld_hold", o_ld, exp_ld[sel]);
    end else begin
      while (!granted && !timed) begin
        check_eq("gnt_req", o_dreq, 1);
        check_eq("gnt_no_done", o_done, 0);
        check_eq("gnt_addr", o_addr, ea);
        check_eq("gnt_be", o_be, ebe);
        check_eq("gnt_wdata", o_wd, ewd);
        check_eq("gnt_we", o_we, st);
        check_eq("gnt_ld_hold", o_ld, exp_ld[sel]);
        err = $urandom_range(0, 1); rdata = {$urandom, $urandom};
        if (k == gd) begin
          gnt = 1'b1; rvalid = $urandom_range(0, 1); granted = 1'b1;
        end else begin
          gnt = 1'b0; rvalid = ($urandom_range(0, 2) == 0);
          if (k == tmo - 1) timed = 1'b1;
        end
        @(negedge clk);
        k++;
      end
      gnt = 1'b0; rvalid = 1'b0;
      k = 0;
      while (granted && !got && !timed) begin
        check_eq("rv_req_low", o_dreq, 0);
        check_eq("rv_no_done", o_done, 0);
        check_eq("rv_ld_hold", o_ld, exp_ld[sel]);
        if (k == rd) begin
          rvalid = 1'b1; err = e; rdata = rdat; got = 1'b1;
        end else begin
          rvalid = 1'b0; err = $urandom_range(0, 1);
          if (k == tmo - 1) timed = 1'b1;
        end
        @(negedge clk);
        k++;
      end
      rvalid = 1'b0; err = 1'b0;
      if (!st) exp_ld[sel] = (got && !e) ? model_load(w, u, a, rdat, nb) : 32'h0;
      check_eq("end_done", o_done, 1);
      check_eq("end_berr", o_berr, got ? e : 1'b1);
      check_eq("end_mis", o_mis, 0);
      check_eq("end_req_low", o_dreq, 0);
      check_eq("end_ready", o_ready, 1);
      check_eq("end_ld", o_ld, exp_ld[sel]);
    end
    @(negedge clk);
    check_eq("pulse_done_clr", o_done, 0);
    check_eq("pulse_mis_clr", o_mis, 0);
    check_eq("pulse_berr_clr", o_berr, 0);
    check_eq("after_ld_hold", o_ld, exp_ld[sel]);
  endtask

  initial begin
    exp_ld[0] = '0;
    exp_ld[1] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check_eq("rst_ready", o_ready, 1);
      check_eq("rst_done", o_done, 0);
      check_eq("rst_mis", o_mis, 0);
      check_eq("rst_berr", o_berr, 0);
      check_eq("rst_ld", o_ld, 0);
      check_eq("rst_req", o_dreq, 0);
      check_eq("rst_we", o_we, 0);
      check_eq("rst_be", o_be, 0);
      check_eq("rst_addr", o_addr, 0);
      check_eq("rst_wdata", o_wd, 0);
    end
    @(negedge clk);

    // Signed byte load, grant after two cycles
    sel = 1'b0;
    do_txn(1'b0, 1'b0, LsuByte, 32'h103, 32'h0, 2, 0, 1'b0, 64'h80AABBCC);
    check_eq("lb_signext", o_ld, 32'hFFFFFF80);
    // Misaligned word: immediate reject
    do_txn(1'b0, 1'b0, LsuWord, 32'h102, 32'h0, 0, 0, 1'b0, 64'h0);
    // Grant withheld: timeout after four wait cycles
    do_txn(1'b1, 1'b0, LsuWord, 32'h40, 32'hCAFEF00D, 100, 0, 1'b0, 64'h0);
    // Half store on the 64-bit bus at the top lane pair
    sel = 1'b1;
    do_txn(1'b1, 1'b0, LsuHalf, 32'h206, 32'h1234ABCD, 0, 0, 1'b0, 64'h0);

    // Reset while waiting for rvalid; a late rvalid must be ignored
    sel = 1'b0;
    do_txn(1'b0, 1'b1, LsuByte, 32'h1, 32'h0, 0, 0, 1'b0, 64'h0000AB00);
    check_eq("lbu_value", o_ld, 32'hAB);
    req = 1'b1; store = 1'b0; width = LsuWord; addr = 32'h10;
    @(negedge clk);
    req = 1'b0; gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    check_eq("rst_mid_req_low", o_dreq, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ld[0] = '0;
    check_eq("rst_mid_no_done", o_done, 0);
    check_eq("rst_mid_ld", o_ld, 0);
    check_eq("rst_mid_ready", o_ready, 1);
    rvalid = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    rvalid = 1'b0;
    check_eq("late_rv_no_done", o_done, 0);
    check_eq("late_rv_ld", o_ld, 0);
    check_eq("late_rv_req", o_dreq, 0);
    @(negedge clk);

    // Randomised traffic on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int n = 0; n < 120; n++) begin
        lsu_width_e  w   = lsu_width_e'($urandom_range(0, 2));
        logic [31:0] a   = $urandom;
        int          tmo = sel ? 6 : 4;
        int          gd  = ($urandom_range(0, 5) == 0) ? tmo + 1 : $urandom_range(0, 2);
        int          rd  = ($urandom_range(0, 5) == 0) ? tmo + 1 : $urandom_range(0, 2);
        if ($urandom_range(0, 3) != 0) a = a & ~32'(size_of(w) - 1);
        do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w, a, $urandom, gd, rd,
               ($urandom_range(0, 4) == 0), {$urandom, $urandom});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
